pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It collects stall requests from IF/ID/EX/MEM and the exception/ERET request raised at MEM. It drives the per-stage stall vector and the single flush line consumed by every inter-stage pipeline register (IFID, IDEX, EXMEM, MEMWB). On an exception it produces the redirect PC for the PC unit. A small FSM holds a pending exception until an outstanding MEM bus stall resolves, then issues exactly one flush cycle.

Parameters:
ADDR_WIDTH, 32, width of PC/redirect addresses (matches ADDR_BUS_WIDTH)
STALL_CNT_WIDTH, 32, width of optional stall performance counter

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
stall_req_if  in  1  fetch stage waiting on instruction bus
stall_req_id  in  1  load-use hazard detected in ID
stall_req_ex  in  1  multi-cycle mult/div busy in EX
stall_req_mem  in  1  data bus not ready in MEM
exc_req  in  1  MEM stage has an exception (syscall/break/overflow/RI/addr error)
eret_req  in  1  MEM stage holds ERET
exc_handler_addr  in  ADDR_WIDTH  exception vector from CP0
epc_in  in  ADDR_WIDTH  current CP0 EPC
stall_pc  out  1  hold PC
stall_if  out  1  hold IFID register source side
stall_id  out  1  hold ID stage
stall_ex  out  1  hold EX stage
stall_mem  out  1  hold MEM stage
stall_wb  out  1  hold WB stage (never asserted; fixed 0)
flush  out  1  clear all pipeline registers
exc_pc  out  ADDR_WIDTH  PC redirect target, valid while flush=1

Behaviour:
- Reset (rst=1 at posedge): state=RUN. Stall outputs are combinational and equal 0 during reset. flush=0, exc_pc=0.
- Stall vector in RUN, deepest request wins:
  - stall_req_mem -> stall pc..mem = 1.
  - else stall_req_ex -> pc..ex.
  - else stall_req_id -> pc..id.
  - else stall_req_if -> pc..if.
  - else all 0.
- Stalls are contiguous from PC. Each pipeline register receives stall_current_stage=stall[i] and stall_next_stage=stall[i+1]. A bubble is inserted where current=1 and next=0.
- FSM states: RUN, WAIT_MEM, FLUSH.
  - RUN: if (exc_req|eret_req) and !stall_req_mem -> FLUSH. Latch target = eret_req ? epc_in : exc_handler_addr. ERET has priority if both are set.
  - RUN: if (exc_req|eret_req) and stall_req_mem -> WAIT_MEM. Latch the request type.
  - WAIT_MEM: stall pc..mem held at 1. When stall_req_mem=0 -> FLUSH. Target is sampled at that cycle from epc_in/exc_handler_addr per the latched type.
  - FLUSH: flush=1 and exc_pc=target for exactly one cycle. All stall outputs are 0. exc_req/eret_req are ignored. Next state is RUN.
- Detection cycle (RUN with exc/eret request): stall pc..mem forced to 1 combinationally, so younger instructions do not advance before the flush. WB proceeds.
- flush and exc_pc are registered, giving 1-cycle latency from request acceptance to flush. exc_pc holds its last value when flush=0.
- Flush dominates stall in the pipeline registers; stalls are forced 0 in FLUSH regardless.
- A new request in the first RUN cycle after FLUSH is accepted normally, so back-to-back exceptions are spaced 2 cycles apart.
- rst asserted in WAIT_MEM or FLUSH returns to RUN next edge. The pending exception is dropped.

Optional Feature:
STALL_PERF_EN:
- Defined: adds output stall_cycle_cnt [STALL_CNT_WIDTH-1:0].
  - Increments every cycle stall_pc=1.
  - Saturates at all-ones.
  - Reset to 0 by rst.
- Undefined: port and counter absent. Behaviour otherwise identical.

Decomposition:
- Shared package/header (bus.v): ADDR_BUS/ADDR_BUS_WIDTH, FSM state encodings (CTRL_RUN=2'd0, CTRL_WAIT_MEM=2'd1, CTRL_FLUSH=2'd2), stage index constants.
- One natural sub-module: stall_priority_enc, the combinational deepest-request-to-thermometer stall encoder.
- FSM, target latch and optional counter stay in pipeline_ctrl.

Test Plan:
- After reset, stall_req_ex=1 for 3 cycles -> stall_pc/if/id/ex=1, stall_mem=0 for those 3 cycles; all return to 0 the cycle after the request drops.
- stall_req_id=1 and stall_req_mem=1 together -> stalls pc..mem=1 (MEM dominates); flush=0.
- exc_req=1 with exc_handler_addr=0xBFC00380, no mem stall -> next cycle flush=1 and exc_pc=0xBFC00380 for exactly one cycle; stalls 0 during flush.
- exc_req=1 while stall_req_mem=1 for 4 cycles -> FSM in WAIT_MEM, stalls pc..mem=1, flush=0. One cycle after stall_req_mem falls, flush=1 with the handler address.
- eret_req=1 and exc_req=1 simultaneously with epc_in=0x80001234 -> flush=1 with exc_pc=0x80001234.
- rst pulse while in WAIT_MEM -> next cycle state RUN, flush=0, no later flush. With STALL_PERF_EN, counter reads 0 after reset and equals the number of stall_pc=1 cycles otherwise.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: address bus width,
// FSM encodings, stage indices and the stall request/vector types.
package pipeline_ctrl_pkg;

    localparam int ADDR_BUS_WIDTH = 32;
    typedef logic [ADDR_BUS_WIDTH-1:0] addr_bus_t;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_WAIT_MEM = 2'd1,
        CTRL_FLUSH    = 2'd2
    } ctrl_state_e;

    localparam int STG_PC     = 0;
    localparam int STG_IF     = 1;
    localparam int STG_ID     = 2;
    localparam int STG_EX     = 3;
    localparam int STG_MEM    = 4;
    localparam int STG_WB     = 5;
    localparam int NUM_STAGES = 6;

    typedef logic [NUM_STAGES-1:0] stall_vec_t;

    typedef struct packed {
        logic req_if;
        logic req_id;
        logic req_ex;
        logic req_mem;
    } stall_req_t;

    // Thermometer mask: every stage from PC up to and including `depth`.
    function automatic stall_vec_t stall_upto(input int depth);
        stall_vec_t v;
        v = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= depth) v[i] = 1'b1;
        end
        return v;
    endfunction

    localparam stall_vec_t STALL_THRU_MEM = 6'b01_1111;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipeline_ctrl.
// stall_cycle_cnt (and its width parameter) exist only when STALL_PERF_EN is defined.
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32
`ifdef STALL_PERF_EN
    , parameter int STALL_CNT_WIDTH = 32
`endif
);
    logic                  stall_req_if;
    logic                  stall_req_id;
    logic                  stall_req_ex;
    logic                  stall_req_mem;
    logic                  exc_req;
    logic                  eret_req;
    logic [ADDR_WIDTH-1:0] exc_handler_addr;
    logic [ADDR_WIDTH-1:0] epc_in;

    logic                  stall_pc;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  stall_wb;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] exc_pc;
`ifdef STALL_PERF_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cycle_cnt;
`endif

    modport master (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output exc_req, eret_req, exc_handler_addr, epc_in,
        input  stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
        input  flush, exc_pc
`ifdef STALL_PERF_EN
        , input stall_cycle_cnt
`endif
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  exc_req, eret_req, exc_handler_addr, epc_in,
        output stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
        output flush, exc_pc
`ifdef STALL_PERF_EN
        , output stall_cycle_cnt
`endif
    );

endinterface

// File: rtl/pipeline_ctrl_stall_priority_enc.sv
// Deepest-request-wins stall encoder: turns the per-stage requests into a
// contiguous stall mask starting at PC. WB is never stalled.
module stall_priority_enc
    import pipeline_ctrl_pkg::*;
(
    input  stall_req_t i_req,
    output stall_vec_t o_stall
);

    always_comb begin
        o_stall = '0;
        if (i_req.req_mem)     o_stall = stall_upto(STG_MEM);
        else if (i_req.req_ex) o_stall = stall_upto(STG_EX);
        else if (i_req.req_id) o_stall = stall_upto(STG_ID);
        else if (i_req.req_if) o_stall = stall_upto(STG_IF);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Optional stall
// performance counter is compiled in with the STALL_PERF_EN macro.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS_WIDTH
`ifdef STALL_PERF_EN
    , parameter int STALL_CNT_WIDTH = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_e           r_state;
    logic                  r_is_eret;
    logic                  r_flush;
    logic [ADDR_WIDTH-1:0] r_exc_pc;

    stall_req_t            w_req;
    stall_vec_t            w_enc_stall;
    stall_vec_t            w_stall;
    logic                  w_exc_any;
    logic                  w_use_epc;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_req     = {bus.stall_req_if, bus.stall_req_id, bus.stall_req_ex, bus.stall_req_mem};
    assign w_exc_any = bus.exc_req | bus.eret_req;

    stall_priority_enc u_enc (
        .i_req   (w_req),
        .o_stall (w_enc_stall)
    );

    // In RUN the live request picks the vector (ERET wins); in WAIT_MEM the latched type does.
    assign w_use_epc = (r_state == CTRL_RUN) ? bus.eret_req : r_is_eret;
    assign w_target  = w_use_epc ? bus.epc_in : bus.exc_handler_addr;

    // Any accepted or pending exception freezes everything up to MEM so no
    // younger instruction advances before the flush lands.
    always_comb begin
        w_stall = '0;
        if (!rst) begin
            case (r_state)
                CTRL_RUN:      w_stall = w_exc_any ? STALL_THRU_MEM : w_enc_stall;
                CTRL_WAIT_MEM: w_stall = STALL_THRU_MEM;
                default:       w_stall = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CTRL_RUN;
            r_is_eret <= 1'b0;
            r_flush   <= 1'b0;
            r_exc_pc  <= '0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                CTRL_RUN: begin
                    if (w_exc_any) begin
                        if (bus.stall_req_mem) begin
                            r_state   <= CTRL_WAIT_MEM;
                            r_is_eret <= bus.eret_req;
                        end else begin
                            r_state  <= CTRL_FLUSH;
                            r_flush  <= 1'b1;
                            r_exc_pc <= w_target;
                        end
                    end
                end
                CTRL_WAIT_MEM: begin
                    if (!bus.stall_req_mem) begin
                        r_state  <= CTRL_FLUSH;
                        r_flush  <= 1'b1;
                        r_exc_pc <= w_target;
                    end
                end
                CTRL_FLUSH: r_state <= CTRL_RUN;
                default:    r_state <= CTRL_RUN;
            endcase
        end
    end

    assign bus.stall_pc  = w_stall[STG_PC];
    assign bus.stall_if  = w_stall[STG_IF];
    assign bus.stall_id  = w_stall[STG_ID];
    assign bus.stall_ex  = w_stall[STG_EX];
    assign bus.stall_mem = w_stall[STG_MEM];
    assign bus.stall_wb  = w_stall[STG_WB];
    assign bus.flush     = r_flush;
    assign bus.exc_pc    = r_exc_pc;

`ifdef STALL_PERF_EN
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall[STG_PC] && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cycle_cnt = r_stall_cnt;
`endif

endmodule
